muldiv_ctrl: RTL and testbench
==============================

Name: muldiv_ctrl

Overview:
Sequencer for RV32M multiply/divide, sitting beside the EX-stage ALU. It accepts an M-extension operation from EX and runs an iterative shift-add / shift-subtract datapath. It holds the pipeline via a stall output until the result is ready, and presents a one-cycle result that EX muxes into alu_out. It is flushed together with EX.

Parameters:
XLEN, 32, operand/result width
ITER, XLEN, iterations per multiply/divide; must equal XLEN

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-low reset
flush  input  1  EX flush; abort any operation
req_valid  input  1  EX holds a valid M instruction; held stable while stall=1
req_opcode  input  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
req_op1  input  XLEN  forwarded rs1 (multiplicand/dividend)
req_op2  input  XLEN  forwarded rs2 (multiplier/divisor)
stall  output  1  to hazard logic (drives ex_stall)
busy  output  1  FSM not IDLE
result_valid  output  1  result valid this cycle
result  output  XLEN  operation result

Behaviour:
- Reset (rst=0, async): state=IDLE, counter=0, result=0, result_valid=0. stall=0, busy=0.
- FSM states IDLE, CALC, DONE.
- IDLE:
  - req_valid & ~flush -> latch |op1|, |op2|, sign flags and opcode.
  - Special divide case -> DONE with result preloaded; otherwise -> CALC with counter=0.
  - stall is combinationally 1 in the accepting cycle.
- CALC:
  - One radix-2 step per cycle; counter increments.
  - counter==ITER-1 -> DONE. stall=1.
- DONE:
  - result_valid=1, stall=0, req_valid ignored; -> IDLE next cycle.
  - A back-to-back M op is accepted in the following IDLE cycle.
- Latency:
  - Normal op: stall high cycles 0..ITER (33 cycles); result_valid in cycle ITER+1.
  - Special case: result_valid in cycle 1.
- Signed handling:
  - Operate on magnitudes, then conditionally two's-complement the output.
  - MULH: both operands signed. MULHSU: op1 signed only. MULHU/DIVU/REMU: unsigned.
  - Quotient sign = sign(op1) XOR sign(op2); remainder sign = sign(op1).
- Product: 2*XLEN internal. MUL returns bits [XLEN-1:0]; MULH* return [2*XLEN-1:XLEN].
- Special cases, per RISC-V spec, no trap:
  - Divide by zero: DIV/DIVU -> all ones; REM/REMU -> op1.
  - Signed overflow (op1=0x80000000, op2=0xFFFFFFFF): DIV -> 0x80000000; REM -> 0.
- Flush:
  - Any state -> IDLE at next edge; no result_valid for the aborted op. stall is 0 in the flush cycle.
  - flush has priority over req_valid in IDLE.
- result holds its last value outside DONE. Consumers use result only when result_valid=1.

Optional Feature:
Macro MULDIV_FAST_MUL_EN.
- Defined: multiplies bypass CALC and use a registered XLEN*XLEN multiply (IDLE -> DONE); result_valid in cycle 1, stall only in cycle 0. Divides are unchanged.
- Undefined: multiplies use the iterative path with the same ITER+1 latency as divides.

Decomposition:
- core package: muldiv opcode enum (funct3 encodings), XLEN constant, FSM state enum.
- One sub-module, muldiv_iter, is natural: purely sequential datapath registers (accumulator, shift operand, counter) performing one mul or div step per enable. muldiv_ctrl keeps the FSM, sign/special-case logic and the handshake.

Test Plan:
- DIV op1=0x00000014, op2=0xFFFFFFFD -> stall high 33 cycles, result_valid cycle 33, result=0xFFFFFFFA; REM same operands -> 0x00000002.
- DIVU op1=0x1234, op2=0 -> result_valid cycle 1, result=0xFFFFFFFF; REMU -> 0x00001234; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
- op1=op2=0xFFFFFFFF: MUL -> 0x00000001, MULH -> 0x00000000, MULHSU -> 0xFFFFFFFF, MULHU -> 0xFFFFFFFE; MULH 0x80000000*0x80000000 -> 0x40000000.
- DIVU started, flush in cycle 10 -> cycle 11 busy=0, stall=0, no result_valid; new DIVU 100/7 issued cycle 11 -> result 14 in cycle 44.
- Back-to-back: MUL then DIV with req_valid held high through DONE -> DIV accepted only the cycle after DONE, both results correct, no double issue.
- rst driven low mid-CALC (async, between edges) -> stall, busy, result_valid and result go 0 immediately; after release, a new REMU 100/7 returns 2.

Source files
------------

// File: rtl/muldiv_ctrl_pkg.sv
// Shared types for the RV32M multiply/divide sequencer: funct3 opcodes,
// datapath width and FSM states.
package muldiv_ctrl_pkg;

  localparam int unsigned MULDIV_XLEN = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } muldiv_state_e;

  function automatic logic op_is_div(input muldiv_op_e op);
    return op[2];
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative radix-2 datapath: one shift-add multiply step or one restoring
// divide step per enabled cycle on unsigned magnitudes.
module muldiv_iter #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned CW   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic              div_mode,
  input  logic [XLEN-1:0]   op_a,
  input  logic [XLEN-1:0]   op_b,
  output logic [CW-1:0]     count,
  output logic [2*XLEN-1:0] product,
  output logic [XLEN-1:0]   quotient,
  output logic [XLEN-1:0]   remainder
);

  logic [XLEN:0]   acc, acc_n;
  logic [XLEN-1:0] sh, sh_n;
  logic [XLEN-1:0] opb;
  logic [XLEN:0]   mul_sum;
  logic [2*XLEN:0] mul_shift;
  logic [XLEN:0]   div_shift, divisor_x;

  // Multiply: {acc, sh} is a combined right-shifting product/multiplier.
  // Divide: {acc, sh} is a left-shifting partial remainder/quotient.
  always_comb begin
    mul_sum   = {1'b0, acc[XLEN-1:0]} + {1'b0, opb};
    mul_shift = sh[0] ? ({mul_sum, sh} >> 1) : ({acc, sh} >> 1);
    div_shift = {acc[XLEN-1:0], sh[XLEN-1]};
    divisor_x = {1'b0, opb};
    acc_n     = mul_shift[2*XLEN:XLEN];
    sh_n      = mul_shift[XLEN-1:0];
    if (div_mode) begin
      if (div_shift >= divisor_x) begin
        acc_n = div_shift - divisor_x;
        sh_n  = {sh[XLEN-2:0], 1'b1};
      end else begin
        acc_n = div_shift;
        sh_n  = {sh[XLEN-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc   <= '0;
      sh    <= '0;
      opb   <= '0;
      count <= '0;
    end else if (load) begin
      acc   <= '0;
      sh    <= op_a;
      opb   <= op_b;
      count <= '0;
    end else if (step) begin
      acc   <= acc_n;
      sh    <= sh_n;
      count <= count + 1'b1;
    end
  end

  assign product   = {acc[XLEN-1:0], sh};
  assign quotient  = sh;
  assign remainder = acc[XLEN-1:0];

endmodule

// File: rtl/muldiv_ctrl.sv
// RV32M multiply/divide sequencer beside the EX ALU: handshake, FSM, sign and
// special-case handling. Define MULDIV_FAST_MUL_EN for single-cycle multiplies.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = MULDIV_XLEN,
  parameter int unsigned ITER = XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            req_valid,
  input  logic [2:0]      req_opcode,
  input  logic [XLEN-1:0] req_op1,
  input  logic [XLEN-1:0] req_op2,
  output logic            stall,
  output logic            busy,
  output logic            result_valid,
  output logic [XLEN-1:0] result
);

  localparam int unsigned   CW      = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] LAST    = CW'(ITER - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_e state, state_n;
  muldiv_op_e    op, op_q;
  logic          neg_q, pre_q;
  logic [XLEN-1:0] result_q;

  logic            sgn1, sgn2, neg1, neg2;
  logic [XLEN-1:0] mag1, mag2;
  logic            accept, special, fast_take, preload, step_en;
  logic [XLEN-1:0] special_value, fast_value, pre_value, calc_value;

  logic [CW-1:0]     count;
  logic [2*XLEN-1:0] product, product_s;
  logic [XLEN-1:0]   quotient, remainder, quot_s, rem_s;

  always_comb begin
    op   = muldiv_op_e'(req_opcode);
    sgn1 = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    sgn2 = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    neg1 = sgn1 & req_op1[XLEN-1];
    neg2 = sgn2 & req_op2[XLEN-1];
    mag1 = neg1 ? -req_op1 : req_op1;
    mag2 = neg2 ? -req_op2 : req_op2;
    special       = 1'b0;
    special_value = '0;
    if (op_is_div(op)) begin
      if (req_op2 == '0) begin
        special       = 1'b1;
        special_value = ((op == OP_DIV) || (op == OP_DIVU)) ? '1 : req_op1;
      end else if (((op == OP_DIV) || (op == OP_REM)) &&
                   (req_op1 == MIN_NEG) && (req_op2 == '1)) begin
        special       = 1'b1;
        special_value = (op == OP_DIV) ? MIN_NEG : '0;
      end
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_a, fast_b, fast_p;

  // Sign-extended operands make one truncated 2*XLEN multiply cover all variants.
  always_comb begin
    fast_a     = {{XLEN{sgn1 & req_op1[XLEN-1]}}, req_op1};
    fast_b     = {{XLEN{sgn2 & req_op2[XLEN-1]}}, req_op2};
    fast_p     = fast_a * fast_b;
    fast_take  = !op_is_div(op);
    fast_value = (op == OP_MUL) ? fast_p[XLEN-1:0] : fast_p[2*XLEN-1:XLEN];
  end
`else
  assign fast_take  = 1'b0;
  assign fast_value = '0;
`endif

  assign accept    = (state == S_IDLE) && req_valid && !flush;
  assign preload   = special || fast_take;
  assign pre_value = special ? special_value : fast_value;
  assign step_en   = (state == S_CALC) && !flush;

  always_comb begin
    state_n = state;
    stall   = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          stall   = 1'b1;
          state_n = preload ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        stall = !flush;
        if (flush)               state_n = S_IDLE;
        else if (count == LAST)  state_n = S_DONE;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  muldiv_iter #(
    .XLEN (XLEN),
    .CW   (CW)
  ) u_iter (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .step      (step_en),
    .div_mode  (op_is_div(op_q)),
    .op_a      (mag1),
    .op_b      (mag2),
    .count     (count),
    .product   (product),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always_comb begin
    product_s = neg_q ? -product : product;
    quot_s    = neg_q ? -quotient : quotient;
    rem_s     = neg_q ? -remainder : remainder;
    case (op_q)
      OP_MUL:                        calc_value = product_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  calc_value = product_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               calc_value = quot_s;
      default:                       calc_value = rem_s;
    endcase
  end

  // Preloaded results land in result_q on entry to DONE; iterative results are
  // shown combinationally in DONE and captured so result holds afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q     <= OP_MUL;
      neg_q    <= 1'b0;
      pre_q    <= 1'b0;
      result_q <= '0;
    end else begin
      if (accept) begin
        op_q  <= op;
        neg_q <= (op == OP_REM) ? neg1 : (neg1 ^ neg2);
        pre_q <= preload;
        if (preload) result_q <= pre_value;
      end
      if ((state == S_DONE) && !pre_q) result_q <= calc_value;
    end
  end

  assign busy         = (state != S_IDLE);
  assign result_valid = (state == S_DONE);
  assign result       = ((state == S_DONE) && !pre_q) ? calc_value : result_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed self-checking bench for muldiv_ctrl; expected values are hand-computed.
module tb_muldiv_ctrl;

  localparam logic [2:0] C_MUL = 3'd0, C_MULH = 3'd1, C_MULHSU = 3'd2, C_MULHU = 3'd3;
  localparam logic [2:0] C_DIV = 3'd4, C_DIVU = 3'd5, C_REM = 3'd6, C_REMU = 3'd7;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;
  } vec_t;

  logic        clk, rst, flush, req_valid;
  logic [2:0]  req_opcode;
  logic [31:0] req_op1, req_op2;
  logic        stall, busy, result_valid;
  logic [31:0] result;

  int compared   = 0;
  int mismatched = 0;

  muldiv_ctrl #(.XLEN(32), .ITER(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .req_valid    (req_valid),
    .req_opcode   (req_opcode),
    .req_op1      (req_op1),
    .req_op2      (req_op2),
    .stall        (stall),
    .busy         (busy),
    .result_valid (result_valid),
    .result       (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drives one request (called just after a rising edge, DUT idle) and reports
  // the cycle of result_valid relative to the issue cycle.
  task automatic do_op(input logic [2:0] opc, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat, output int stalls,
                       output logic stall_done);
    req_opcode = opc; req_op1 = a; req_op2 = b; req_valid = 1'b1;
    res = '0; lat = -1; stalls = 0; stall_done = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (result_valid) begin
        lat = c; res = result; stall_done = stall;
        break;
      end
      if (stall) stalls++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    compared += 4;
    if (stall !== 1'b0)        begin mismatched++; $display("FAIL reset_stall got=%b exp=0", stall); end
    if (busy !== 1'b0)         begin mismatched++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (result_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid got=%b exp=0", result_valid); end
    if (result !== 32'h0)      begin mismatched++; $display("FAIL reset_result got=%h exp=00000000", result); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("FAIL post_reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_mul;
    vec_t tbl [10];
    logic [31:0] r; int lat, st; logic sd;
    tbl = '{
      '{C_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001},
      '{C_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000},
      '{C_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF},
      '{C_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE},
      '{C_MULH,   32'h80000000, 32'h80000000, 32'h40000000},
      '{C_MUL,    32'h00000003, 32'hFFFFFFF9, 32'hFFFFFFEB},
      '{C_MULH,   32'hFFFFFFF9, 32'h00000003, 32'hFFFFFFFF},
      '{C_MULHSU, 32'h80000000, 32'h00000002, 32'hFFFFFFFF},
      '{C_MULH,   32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF},
      '{C_MULHU,  32'h80000000, 32'h00000002, 32'h00000001}
    };
    for (int i = 0; i < 10; i++) begin
      do_op(tbl[i].op, tbl[i].a, tbl[i].b, r, lat, st, sd);
      compared += 3;
      if (r !== tbl[i].e)  begin mismatched++; $display("FAIL mul[%0d]_result got=%h exp=%h", i, r, tbl[i].e); end
      if (lat !== MUL_LAT) begin mismatched++; $display("FAIL mul[%0d]_latency got=%0d exp=%0d", i, lat, MUL_LAT); end
      if (st !== MUL_LAT)  begin mismatched++; $display("FAIL mul[%0d]_stalls got=%0d exp=%0d", i, st, MUL_LAT); end
    end
  endtask

  task automatic test_div;
    vec_t tbl [7];
    logic [31:0] r; int lat, st; logic sd;
    tbl = '{
      '{C_DIV,  32'h00000014, 32'hFFFFFFFD, 32'hFFFFFFFA},
      '{C_REM,  32'h00000014, 32'hFFFFFFFD, 32'h00000002},
      '{C_DIV,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD},
      '{C_REM,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF},
      '{C_DIVU, 32'hFFFFFFFF, 32'h00000010, 32'h0FFFFFFF},
      '{C_REMU, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F},
      '{C_DIVU, 32'd100,      32'd7,        32'd14}
    };
    for (int i = 0; i < 7; i++) begin
      do_op(tbl[i].op, tbl[i].a, tbl[i].b, r, lat, st, sd);
      compared += 4;
      if (r !== tbl[i].e) begin mismatched++; $display("FAIL div[%0d]_result got=%h exp=%h", i, r, tbl[i].e); end
      if (lat !== 33)     begin mismatched++; $display("FAIL div[%0d]_latency got=%0d exp=33", i, lat); end
      if (st !== 33)      begin mismatched++; $display("FAIL div[%0d]_stalls got=%0d exp=33", i, st); end
      if (sd !== 1'b0)    begin mismatched++; $display("FAIL div[%0d]_stall_in_done got=%b exp=0", i, sd); end
    end
  endtask

  task automatic test_special;
    vec_t tbl [6];
    logic [31:0] r; int lat, st; logic sd;
    tbl = '{
      '{C_DIVU, 32'h00001234, 32'h00000000, 32'hFFFFFFFF},
      '{C_REMU, 32'h00001234, 32'h00000000, 32'h00001234},
      '{C_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000},
      '{C_REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000},
      '{C_DIV,  32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFF},
      '{C_REM,  32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB}
    };
    for (int i = 0; i < 6; i++) begin
      do_op(tbl[i].op, tbl[i].a, tbl[i].b, r, lat, st, sd);
      compared += 3;
      if (r !== tbl[i].e) begin mismatched++; $display("FAIL special[%0d]_result got=%h exp=%h", i, r, tbl[i].e); end
      if (lat !== 1)      begin mismatched++; $display("FAIL special[%0d]_latency got=%0d exp=1", i, lat); end
      if (st !== 1)       begin mismatched++; $display("FAIL special[%0d]_stalls got=%0d exp=1", i, st); end
    end
  endtask

  task automatic test_flush;
    int seen = 0;
    logic [31:0] r; int lat, st; logic sd;
    req_opcode = C_DIVU; req_op1 = 32'h1000; req_op2 = 32'd3; req_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (result_valid) seen++;
      @(posedge clk); #1;
    end
    req_valid = 1'b0; flush = 1'b1;
    @(negedge clk);
    compared++;
    if (stall !== 1'b0) begin mismatched++; $display("FAIL flush_cycle_stall got=%b exp=0", stall); end
    if (result_valid) seen++;
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    compared += 4;
    if (busy !== 1'b0)         begin mismatched++; $display("FAIL flush_busy got=%b exp=0", busy); end
    if (stall !== 1'b0)        begin mismatched++; $display("FAIL flush_stall got=%b exp=0", stall); end
    if (result_valid !== 1'b0) begin mismatched++; $display("FAIL flush_valid got=%b exp=0", result_valid); end
    if (seen !== 0)            begin mismatched++; $display("FAIL flush_aborted_valids got=%0d exp=0", seen); end
    do_op(C_DIVU, 32'd100, 32'd7, r, lat, st, sd);
    compared += 2;
    if (r !== 32'd14) begin mismatched++; $display("FAIL flush_next_result got=%h exp=0000000e", r); end
    if (lat !== 33)   begin mismatched++; $display("FAIL flush_next_latency got=%0d exp=33", lat); end
    // flush wins over a simultaneous request in IDLE
    req_opcode = C_DIVU; req_op1 = 32'd9; req_op2 = 32'd2; req_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    compared++;
    if (stall !== 1'b0) begin mismatched++; $display("FAIL flush_prio_stall got=%b exp=0", stall); end
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    #1;
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("FAIL flush_prio_busy got=%b exp=0", busy); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] r1 = '0, r2 = '0;
    int lat1 = -1, lat2 = -1, pulses = 0;
    logic acc_stall = 1'b0, acc_busy = 1'b1;
    req_opcode = C_MUL; req_op1 = 32'd6; req_op2 = 32'd7; req_valid = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (result_valid) begin pulses++; lat1 = c; r1 = result; break; end
      @(posedge clk); #1;
    end
    req_opcode = C_DIV; req_op1 = 32'd100; req_op2 = 32'hFFFFFFF6;
    @(posedge clk); #1;
    @(negedge clk);
    acc_stall = stall; acc_busy = busy;
    if (result_valid) pulses++;
    for (int c = 1; c < 60; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (result_valid) begin pulses++; lat2 = c; r2 = result; break; end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (result_valid) pulses++;
    end
    @(posedge clk); #1;
    compared += 7;
    if (r1 !== 32'd42)        begin mismatched++; $display("FAIL b2b_mul_result got=%h exp=0000002a", r1); end
    if (lat1 !== MUL_LAT)     begin mismatched++; $display("FAIL b2b_mul_latency got=%0d exp=%0d", lat1, MUL_LAT); end
    if (acc_stall !== 1'b1)   begin mismatched++; $display("FAIL b2b_accept_stall got=%b exp=1", acc_stall); end
    if (acc_busy !== 1'b0)    begin mismatched++; $display("FAIL b2b_accept_busy got=%b exp=0", acc_busy); end
    if (r2 !== 32'hFFFFFFF6)  begin mismatched++; $display("FAIL b2b_div_result got=%h exp=fffffff6", r2); end
    if (lat2 !== 33)          begin mismatched++; $display("FAIL b2b_div_latency got=%0d exp=33", lat2); end
    if (pulses !== 2)         begin mismatched++; $display("FAIL b2b_valid_pulses got=%0d exp=2", pulses); end
  endtask

  task automatic test_async_reset;
    logic pre_busy;
    logic [31:0] r; int lat, st; logic sd;
    req_opcode = C_REMU; req_op1 = 32'd100; req_op2 = 32'd7; req_valid = 1'b1;
    repeat (5) @(posedge clk);
    #3;
    pre_busy = busy;
    rst = 1'b0; req_valid = 1'b0;
    #1;
    compared += 5;
    if (pre_busy !== 1'b1)     begin mismatched++; $display("FAIL areset_pre_busy got=%b exp=1", pre_busy); end
    if (stall !== 1'b0)        begin mismatched++; $display("FAIL areset_stall got=%b exp=0", stall); end
    if (busy !== 1'b0)         begin mismatched++; $display("FAIL areset_busy got=%b exp=0", busy); end
    if (result_valid !== 1'b0) begin mismatched++; $display("FAIL areset_valid got=%b exp=0", result_valid); end
    if (result !== 32'h0)      begin mismatched++; $display("FAIL areset_result got=%h exp=00000000", result); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    do_op(C_REMU, 32'd100, 32'd7, r, lat, st, sd);
    compared += 2;
    if (r !== 32'd2) begin mismatched++; $display("FAIL areset_next_result got=%h exp=00000002", r); end
    if (lat !== 33)  begin mismatched++; $display("FAIL areset_next_latency got=%0d exp=33", lat); end
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; req_valid = 1'b0;
    req_opcode = '0; req_op1 = '0; req_op2 = '0;
    test_reset;
    test_mul;
    test_div;
    test_special;
    test_flush;
    test_back_to_back;
    test_async_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
